axi_sram_slave: RTL and testbench
=================================

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 Parameter MEM_AW, default 12, word-address width; depth is 2^MEM_AW 32-bit words (16 KiB).
REQ-002 Parameter INIT_ZERO, default 0; when 1, the array is zero-filled at elaboration time only.
REQ-003 clk  input  1  sole clock; all logic is rising-edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 arid/araddr/arlen/arsize/arburst  input  4/32/8/3/2  read address channel.
REQ-006 arlock/arcache/arprot  input  2/4/3  accepted and ignored.
REQ-007 arvalid input 1, arready output 1  read address handshake.
REQ-008 rid/rdata/rresp/rlast/rvalid  output  4/32/2/1/1  read data channel; rready input 1.
REQ-009 awid/awaddr/awlen/awsize/awburst  input  4/32/8/3/2  write address channel; awlock/awcache/awprot input 2/4/3, ignored.
REQ-010 awvalid input 1, awready output 1  write address handshake.
REQ-011 wid/wdata/wstrb/wlast/wvalid  input  4/32/4/1/1  write data channel; wready output 1.
REQ-012 bid/bresp/bvalid  output  4/2/1  write response; bready input 1.

Function
REQ-013 Read and write paths SHALL be independent FSMs; each holds at most one outstanding burst.
REQ-014 Read FSM states: R_IDLE, R_LOAD, R_DATA. arready SHALL be 1 only in R_IDLE.
REQ-015 On an AR handshake, the block SHALL latch arid, araddr[MEM_AW+1:2], arlen and arburst, then go to R_LOAD.
REQ-016 R_LOAD SHALL read the array into the rdata register and go to R_DATA; the first rvalid is therefore asserted 2 cycles after the AR handshake.
REQ-017 In R_DATA, rvalid=1, rid=latched id, rresp=2'b00, and rlast=1 when beat count == arlen.
REQ-018 rdata, rlast and rid SHALL stay stable while rvalid & ~rready.
REQ-019 On each accepted non-last beat: pointer +1 for INCR or WRAP, unchanged for FIXED; count +1; return to R_LOAD.
REQ-020 On the accepted last beat, the read FSM SHALL return to R_IDLE.
REQ-021 Write FSM states: W_IDLE, W_DATA, W_RESP. awready SHALL be 1 only in W_IDLE; wready SHALL be 1 only in W_DATA.
REQ-022 On an AW handshake, the block SHALL latch awid, awaddr[MEM_AW+1:2] and awburst, then go to W_DATA.
REQ-023 On each W handshake, mem[ptr] byte i SHALL be written where wstrb[i]=1; the pointer advances as in REQ-019.
REQ-024 W_DATA SHALL exit to W_RESP when wlast=1; wid and awlen are not checked.
REQ-025 In W_RESP, bvalid=1, bid=latched awid, bresp=2'b00; on bready the FSM SHALL return to W_IDLE.
REQ-026 Address bits above MEM_AW+1 SHALL be ignored (aliasing); the pointer SHALL wrap modulo 2^MEM_AW.
REQ-027 arsize/awsize SHALL be ignored; byte lanes are selected only by wstrb, and reads always return the full word.
REQ-028 A same-cycle read load and write to the same word SHALL be read-first (old data returned).
REQ-029 wvalid before AW is legal; W SHALL wait, with wready=0, until the AW handshake completes.

Reset
REQ-030 While reset=1: arready=0, awready=0, wready=0, rvalid=0, bvalid=0, rlast=0, rid=0, bid=0, rresp=0, bresp=0, rdata=0.
REQ-031 Reset at any point, including mid-burst, SHALL return both FSMs to idle and drop in-flight transactions; array contents SHALL be preserved.
REQ-032 In the first cycle after reset deasserts, arready=1 and awready=1.

Structure
REQ-033 A shared package axi_pkg SHALL hold BURST_FIXED/INCR/WRAP, RESP_OKAY, the read/write state encodings and the ID width (4).
REQ-034 The storage SHALL be the sub-module sram_1r1w_be: synchronous read-first read port, byte-enable write port, MEM_AW parameter.

Verification
REQ-035 Write 0xDEADBEEF at 0x100 with len 0 and wstrb 0xF, then read 0x100 with len 0 -> rdata 0xDEADBEEF, rlast=1, bresp=0, bid/rid echo the request ids.
REQ-036 Read 0x200 with arlen=3, INCR, arid=1 -> 4 beats from words 0x80–0x83 in order, rlast only on beat 4, first rvalid 2 cycles after the handshake.
REQ-037 Write 0x11223344 with wstrb=0x5 over 0xAABBCCDD -> read returns 0xAA22CC44.
REQ-038 Hold rready=0 for 5 cycles mid-burst -> rdata/rlast stable; no beat lost or duplicated.
REQ-039 wvalid raised 3 cycles before awvalid -> wready stays 0 until the AW handshake; data lands at awaddr.
REQ-040 Assert reset during beat 2 of a len-3 read -> rvalid=0 the next cycle; a new read then returns the correct, preserved data.

Source files
------------

// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI encodings, ID width and FSM state types for the SRAM slave.
package axi_pkg;
  localparam int ID_W = 4;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  typedef enum logic [1:0] {R_IDLE, R_LOAD, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  // WRAP is treated like INCR; only FIXED holds the pointer
  function automatic logic advances(input logic [1:0] burst);
    return burst != BURST_FIXED;
  endfunction
endpackage

// File: rtl/sram_1r1w_be.sv
// sram_1r1w_be: 32-bit word SRAM, synchronous read-first read port and byte-enable write port.
module sram_1r1w_be #(
  parameter int MEM_AW = 12,
  parameter bit INIT_ZERO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re,
  input  logic [MEM_AW-1:0] raddr,
  output logic [31:0]       q,
  input  logic              we,
  input  logic [MEM_AW-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        be
);
  localparam int DEPTH = 1 << MEM_AW;
  // only the read register is reset; stored words survive reset
  if (INIT_ZERO) begin : g_mem
    logic [31:0] mem [DEPTH] = '{default: '0};
    always_ff @(posedge clk) begin
      if (we)
        for (int i = 0; i < 4; i++)
          if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      if (rst) q <= '0;
      else if (re) q <= mem[raddr];
    end
  end else begin : g_mem
    logic [31:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (we)
        for (int i = 0; i < 4; i++)
          if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      if (rst) q <= '0;
      else if (re) q <= mem[raddr];
    end
  end
endmodule

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3 slave over a 2^MEM_AW x 32 SRAM with independent single-burst read and write FSMs.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int MEM_AW = 12,
  parameter bit INIT_ZERO = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [ID_W-1:0] arid,
  input  logic [31:0]     araddr,
  input  logic [7:0]      arlen,
  input  logic [2:0]      arsize,
  input  logic [1:0]      arburst,
  input  logic [1:0]      arlock,
  input  logic [3:0]      arcache,
  input  logic [2:0]      arprot,
  input  logic            arvalid,
  output logic            arready,
  output logic [ID_W-1:0] rid,
  output logic [31:0]     rdata,
  output logic [1:0]      rresp,
  output logic            rlast,
  output logic            rvalid,
  input  logic            rready,
  input  logic [ID_W-1:0] awid,
  input  logic [31:0]     awaddr,
  input  logic [7:0]      awlen,
  input  logic [2:0]      awsize,
  input  logic [1:0]      awburst,
  input  logic [1:0]      awlock,
  input  logic [3:0]      awcache,
  input  logic [2:0]      awprot,
  input  logic            awvalid,
  output logic            awready,
  input  logic [ID_W-1:0] wid,
  input  logic [31:0]     wdata,
  input  logic [3:0]      wstrb,
  input  logic            wlast,
  input  logic            wvalid,
  output logic            wready,
  output logic [ID_W-1:0] bid,
  output logic [1:0]      bresp,
  output logic            bvalid,
  input  logic            bready
);
  rstate_t rs, rs_n;
  wstate_t ws, ws_n;
  logic live;
  logic [ID_W-1:0] rid_q, bid_q;
  logic [MEM_AW-1:0] rptr, wptr;
  logic [7:0] rlen, rcnt;
  logic [1:0] rburst, wburst;
  logic we;
  logic unused_ok;
  assign unused_ok = ^{araddr[31:MEM_AW+2], araddr[1:0], awaddr[31:MEM_AW+2], awaddr[1:0],
                       arsize, awsize, awlen, arlock, arcache, arprot, awlock, awcache, awprot, wid};
  // live holds the ready outputs low while reset is applied
  always_ff @(posedge clk) begin
    if (reset) begin
      live <= 1'b0;
      rs <= R_IDLE;
      ws <= W_IDLE;
      rid_q <= '0;
      bid_q <= '0;
      rptr <= '0;
      wptr <= '0;
      rlen <= '0;
      rcnt <= '0;
      rburst <= BURST_INCR;
      wburst <= BURST_INCR;
    end else begin
      live <= 1'b1;
      rs <= rs_n;
      ws <= ws_n;
      if (arvalid && arready) begin
        rid_q <= arid;
        rptr <= araddr[MEM_AW+1:2];
        rlen <= arlen;
        rburst <= arburst;
        rcnt <= '0;
      end
      if (rvalid && rready && !rlast) begin
        rptr <= rptr + MEM_AW'(advances(rburst));
        rcnt <= rcnt + 8'd1;
      end
      if (awvalid && awready) begin
        bid_q <= awid;
        wptr <= awaddr[MEM_AW+1:2];
        wburst <= awburst;
      end
      if (we) wptr <= wptr + MEM_AW'(advances(wburst));
    end
  end
  always_comb begin
    rs_n = rs;
    if (rs == R_IDLE && arvalid && live) rs_n = R_LOAD;
    if (rs == R_LOAD) rs_n = R_DATA;
    if (rs == R_DATA && rready) rs_n = rlast ? R_IDLE : R_LOAD;
  end
  always_comb begin
    ws_n = ws;
    if (ws == W_IDLE && awvalid && live) ws_n = W_DATA;
    if (ws == W_DATA && wvalid && wlast) ws_n = W_RESP;
    if (ws == W_RESP && bready) ws_n = W_IDLE;
  end
  assign arready = live && rs == R_IDLE;
  assign rvalid = rs == R_DATA;
  assign rlast = rvalid && rcnt == rlen;
  assign rid = rid_q;
  assign rresp = RESP_OKAY;
  assign awready = live && ws == W_IDLE;
  assign wready = ws == W_DATA;
  assign we = wvalid && wready;
  assign bvalid = ws == W_RESP;
  assign bid = bid_q;
  assign bresp = RESP_OKAY;
  sram_1r1w_be #(.MEM_AW(MEM_AW), .INIT_ZERO(INIT_ZERO)) u_sram (
    .clk(clk),
    .rst(reset),
    .re(rs == R_LOAD),
    .raddr(rptr),
    .q(rdata),
    .we(we),
    .waddr(wptr),
    .wdata(wdata),
    .be(wstrb)
  );
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed AXI read/write sequences with hand-computed expectations.
module tb_axi_sram_slave;
  import axi_pkg::*;
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] arid = '0, awid = '0, wid = '0;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
  logic [7:0] arlen = '0, awlen = '0;
  logic [2:0] arsize = 3'd2, awsize = 3'd2, arprot = '0, awprot = '0;
  logic [1:0] arburst = BURST_INCR, awburst = BURST_INCR, arlock = '0, awlock = '0;
  logic [3:0] arcache = '0, awcache = '0, wstrb = '0;
  logic arvalid = 0, rready = 0, awvalid = 0, wvalid = 0, wlast = 0, bready = 0;
  logic arready, rlast, rvalid, awready, wready, bvalid;
  logic [3:0] rid, bid;
  logic [31:0] rdata;
  logic [1:0] rresp, bresp;
  int n_chk = 0, n_fail = 0;
  logic [31:0] wd [0:7];
  logic [31:0] ex [0:7];

  always #5 clk = ~clk;

  axi_sram_slave dut (
    .clk(clk), .reset(reset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                    input logic [1:0] burst, input logic [3:0] strb);
    int t;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1;
    t = 0;
    while (!awready && t < 16) begin step(); t++; end
    chk("aw_wait", 32'(t < 16), 1);
    step();
    awvalid = 0;
    for (int b = 0; b <= int'(len); b++) begin
      wdata = wd[b]; wstrb = strb; wlast = (b == int'(len)); wvalid = 1;
      t = 0;
      while (!wready && t < 16) begin step(); t++; end
      chk("w_wait", 32'(t < 16), 1);
      step();
    end
    wvalid = 0; wlast = 0; bready = 1;
    t = 0;
    while (!bvalid && t < 16) begin step(); t++; end
    chk("b_wait", 32'(t < 16), 1);
    chk("bid", 32'(bid), 32'(id));
    chk("bresp", 32'(bresp), 0);
    step();
    bready = 0;
  endtask

  task automatic rd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                    input logic [1:0] burst, input int stall_at);
    int t;
    logic [31:0] hd;
    logic hl;
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1;
    t = 0;
    while (!arready && t < 16) begin step(); t++; end
    chk("ar_wait", 32'(t < 16), 1);
    step();
    arvalid = 0;
    chk("r_load_gap", 32'(rvalid), 0);
    step();
    chk("r_first_latency", 32'(rvalid), 1);
    for (int b = 0; b <= int'(len); b++) begin
      t = 0;
      while (!rvalid && t < 16) begin step(); t++; end
      chk("r_wait", 32'(t < 16), 1);
      if (b == stall_at) begin
        hd = rdata; hl = rlast;
        repeat (5) begin
          step();
          chk("stall_rvalid", 32'(rvalid), 1);
          chk("stall_rdata", rdata, hd);
          chk("stall_rlast", 32'(rlast), 32'(hl));
        end
      end
      chk($sformatf("rdata[%0d]", b), rdata, ex[b]);
      chk($sformatf("rlast[%0d]", b), 32'(rlast), 32'(b == int'(len)));
      chk("rid", 32'(rid), 32'(id));
      chk("rresp", 32'(rresp), 0);
      rready = 1;
      step();
      rready = 0;
    end
    chk("r_back_idle", 32'(arready), 1);
  endtask

  initial begin
    int t;
    repeat (3) step();
    chk("rst_arready", 32'(arready), 0);
    chk("rst_awready", 32'(awready), 0);
    chk("rst_wready", 32'(wready), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rlast", 32'(rlast), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rid", 32'(rid), 0);
    chk("rst_bid", 32'(bid), 0);
    reset = 0;
    step();
    chk("post_rst_arready", 32'(arready), 1);
    chk("post_rst_awready", 32'(awready), 1);

    wd[0] = 32'hDEADBEEF;
    wr(4'd5, 32'h100, 8'd0, BURST_INCR, 4'hF);
    ex[0] = 32'hDEADBEEF;
    rd(4'd9, 32'h100, 8'd0, BURST_INCR, -1);

    wd[0] = 32'h11110000; wd[1] = 32'h22220001; wd[2] = 32'h33330002; wd[3] = 32'h44440003;
    wr(4'd2, 32'h200, 8'd3, BURST_INCR, 4'hF);
    ex[0] = 32'h11110000; ex[1] = 32'h22220001; ex[2] = 32'h33330002; ex[3] = 32'h44440003;
    rd(4'd1, 32'h200, 8'd3, BURST_INCR, 1);

    ex[0] = 32'h11110000; ex[1] = 32'h11110000; ex[2] = 32'h11110000;
    rd(4'd6, 32'h200, 8'd2, BURST_FIXED, -1);

    wd[0] = 32'hAABBCCDD;
    wr(4'd7, 32'h300, 8'd0, BURST_INCR, 4'hF);
    wd[0] = 32'h11223344;
    wr(4'd8, 32'h300, 8'd0, BURST_INCR, 4'h5);
    ex[0] = 32'hAA22CC44;
    rd(4'd4, 32'h300, 8'd0, BURST_INCR, -1);

    ex[0] = 32'hDEADBEEF;
    rd(4'd3, 32'h4100, 8'd0, BURST_INCR, -1);

    wd[0] = 32'h5A5A0001; wd[1] = 32'h5A5A0002;
    wr(4'd10, 32'h3FFC, 8'd1, BURST_WRAP, 4'hF);
    ex[0] = 32'h5A5A0002;
    rd(4'd11, 32'h0, 8'd0, BURST_INCR, -1);
    ex[0] = 32'h5A5A0001; ex[1] = 32'h5A5A0002;
    rd(4'd12, 32'h3FFC, 8'd1, BURST_INCR, -1);

    wdata = 32'hCAFEF00D; wstrb = 4'hF; wlast = 1; wvalid = 1;
    repeat (3) begin
      step();
      chk("early_w_wready", 32'(wready), 0);
    end
    awid = 4'd3; awaddr = 32'h400; awlen = 8'd0; awburst = BURST_INCR; awvalid = 1;
    t = 0;
    while (!awready && t < 16) begin step(); t++; end
    chk("early_aw_wait", 32'(t < 16), 1);
    chk("early_wready_pre_aw", 32'(wready), 0);
    step();
    awvalid = 0;
    chk("early_wready_post_aw", 32'(wready), 1);
    step();
    wvalid = 0; wlast = 0; bready = 1;
    t = 0;
    while (!bvalid && t < 16) begin step(); t++; end
    chk("early_b_wait", 32'(t < 16), 1);
    chk("early_bid", 32'(bid), 3);
    step();
    bready = 0;
    ex[0] = 32'hCAFEF00D;
    rd(4'd13, 32'h400, 8'd0, BURST_INCR, -1);

    arid = 4'd2; araddr = 32'h200; arlen = 8'd3; arburst = BURST_INCR; arvalid = 1;
    t = 0;
    while (!arready && t < 16) begin step(); t++; end
    step();
    arvalid = 0;
    t = 0;
    while (!rvalid && t < 16) begin step(); t++; end
    chk("mid_beat1", rdata, 32'h11110000);
    rready = 1;
    step();
    rready = 0;
    t = 0;
    while (!rvalid && t < 16) begin step(); t++; end
    chk("mid_beat2", rdata, 32'h22220001);
    reset = 1;
    step();
    chk("mid_rst_rvalid", 32'(rvalid), 0);
    chk("mid_rst_arready", 32'(arready), 0);
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_rid", 32'(rid), 0);
    reset = 0;
    step();
    chk("mid_post_arready", 32'(arready), 1);
    chk("mid_post_awready", 32'(awready), 1);
    ex[0] = 32'h11110000; ex[1] = 32'h22220001; ex[2] = 32'h33330002; ex[3] = 32'h44440003;
    rd(4'd14, 32'h200, 8'd3, BURST_INCR, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
